// File: rtl/soc_glip_arbiter_pkg.sv
// Shared types and helpers for the GLIP channel arbiter.
package soc_glip_arbiter_pkg;

  // Widest header word the length helper accepts.
  localparam int HDR_MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    HEAD,
    PAYLOAD
  } arb_state_e;

  // Length field: the low lenw bits of the header word, zero-extended.
  function automatic logic [HDR_MAX_W-1:0] glip_hdr_len(
    input logic [HDR_MAX_W-1:0] header,
    input int                   lenw
  );
    logic [HDR_MAX_W-1:0] len;
    len = '0;
    for (int b = 0; b < HDR_MAX_W; b++) begin
      if (b < lenw) len[b] = header[b];
    end
    return len;
  endfunction

endpackage

// File: rtl/soc_glip_rr_arbiter.sv
// Combinational cyclic priority pick: first requester at or after ptr.
module soc_glip_rr_arbiter #(
  parameter  int PORTS = 4,
  localparam int PW    = $clog2(PORTS)
) (
  input  logic [PORTS-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [PW-1:0]    gnt_idx,
  output logic             any
);

  int j;

  // Scan from the far end so the closest requester to ptr wins last.
  always_comb begin
    gnt_idx = '0;
    any     = |req;
    j       = 0;
    for (int i = PORTS - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= PORTS) j = j - PORTS;
      if (req[j]) gnt_idx = PW'(j);
    end
  end

endmodule

// File: rtl/soc_glip_channel_arbiter.sv
// Packet-aware round-robin arbiter sharing one GLIP channel among PORTS requesters.
module soc_glip_channel_arbiter
  import soc_glip_arbiter_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int PORTS = 4,
  parameter  int LENW  = 8,
  localparam int PW    = $clog2(PORTS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PORTS*WIDTH-1:0] in_data,
  input  logic [PORTS-1:0]       in_valid,
  output logic [PORTS-1:0]       in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PW-1:0]          grant,
  output logic                   busy
);

  localparam logic [PW-1:0] LAST_PORT = PW'(PORTS - 1);

  arb_state_e      state, state_d;
  logic [PW-1:0]   grant_d, rr_ptr, rr_ptr_d, pick;
  logic [LENW-1:0] remaining, remaining_d, hdr_len;
  logic            any_req, xfer;

  soc_glip_rr_arbiter #(.PORTS(PORTS)) u_rr (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .gnt_idx (pick),
    .any     (any_req)
  );

  // Zero-latency pass-through of the owner while a packet is in flight.
  assign busy      = (state != IDLE);
  assign out_data  = in_data[grant*WIDTH +: WIDTH];
  assign out_valid = busy & in_valid[grant];
  assign xfer      = out_valid & out_ready;
  assign hdr_len   = LENW'(glip_hdr_len(HDR_MAX_W'(out_data), LENW));

  always_comb begin
    in_ready = '0;
    if (busy) in_ready[grant] = out_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      remaining <= '0;
    end else begin
      state     <= state_d;
      grant     <= grant_d;
      rr_ptr    <= rr_ptr_d;
      remaining <= remaining_d;
    end
  end

  always_comb begin
    state_d     = state;
    grant_d     = grant;
    rr_ptr_d    = rr_ptr;
    remaining_d = remaining;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          state_d  = HEAD;
          grant_d  = pick;
          rr_ptr_d = (pick == LAST_PORT) ? '0 : pick + 1'b1;
        end
      end
      HEAD: begin
        if (xfer) begin
          remaining_d = hdr_len;
          state_d     = (hdr_len == '0) ? IDLE : PAYLOAD;
        end
      end
      PAYLOAD: begin
        // Guarded decrement: the counter can never wrap below zero.
        if (xfer && remaining != '0) begin
          remaining_d = remaining - 1'b1;
          if (remaining == LENW'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_soc_glip_channel_arbiter.sv
// Self-checking bench: per-port word queues feed the arbiter, transfers are logged and compared.
module tb_soc_glip_channel_arbiter;

  localparam int W = 16;
  localparam int P = 4;
  localparam int L = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [P*W-1:0] idata;
  logic [P-1:0]   iv, ir;
  logic [W-1:0]   od;
  logic           ov, oready;
  logic [1:0]     gnt;
  logic           busy;

  soc_glip_channel_arbiter #(.WIDTH(W), .PORTS(P), .LENW(L)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (idata),
    .in_valid  (iv),
    .in_ready  (ir),
    .out_data  (od),
    .out_valid (ov),
    .out_ready (oready),
    .grant     (gnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  logic [W-1:0] mem [P][300];
  int           hd [P];
  int           tl [P];
  logic [W-1:0] lg_data [300];
  int           lg_gnt [300];
  int           lg_cyc [300];
  int           lg_n, cyc_n;
  logic [P-1:0] popf;

  typedef struct {
    int          ld_port;
    logic [15:0] ld_word;
    logic        busy;
    logic [1:0]  grant;
    logic        ov;
    logic [15:0] od;
    logic [3:0]  ir;
  } row_t;

  row_t tbl [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int p, input logic [W-1:0] w);
    mem[p][tl[p]] = w;
    tl[p]++;
  endtask

  task automatic refresh();
    for (int i = 0; i < P; i++) begin
      iv[i]           = (hd[i] < tl[i]);
      idata[i*W +: W] = (hd[i] < tl[i]) ? mem[i][hd[i]] : '0;
    end
  endtask

  task automatic clear_q();
    for (int i = 0; i < P; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
  endtask

  // Log this cycle's handshakes, cross the clock edge, then advance the requester queues.
  task automatic cyc();
    #1;
    for (int i = 0; i < P; i++) popf[i] = iv[i] & ir[i];
    if (ov && oready && lg_n < 300) begin
      lg_data[lg_n] = od;
      lg_gnt[lg_n]  = int'(gnt);
      lg_cyc[lg_n]  = cyc_n;
      lg_n++;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < P; i++) if (popf[i]) hd[i]++;
    refresh();
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    oready = 1'b1;
    clear_q();
    refresh();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    cyc_n = 0;
    lg_n  = 0;
    #1;
  endtask

  initial begin
    logic [15:0] pat;
    logic [15:0] w;
    int          ord [3];
    int          pkt, p, k, bad;

    // Port 2 packet len 3, then port 1 single-word packet (rr_ptr is 3 after port 2).
    tbl[0] = '{2,  16'h0003, 1'b0, 2'd0, 1'b0, 16'h0000, 4'b0000};
    tbl[1] = '{2,  16'h00A1, 1'b1, 2'd2, 1'b1, 16'h0003, 4'b0100};
    tbl[2] = '{2,  16'h00A2, 1'b1, 2'd2, 1'b1, 16'h00A1, 4'b0100};
    tbl[3] = '{2,  16'h00A3, 1'b1, 2'd2, 1'b1, 16'h00A2, 4'b0100};
    tbl[4] = '{-1, 16'h0000, 1'b1, 2'd2, 1'b1, 16'h00A3, 4'b0100};
    tbl[5] = '{-1, 16'h0000, 1'b0, 2'd0, 1'b0, 16'h0000, 4'b0000};
    tbl[6] = '{1,  16'h5500, 1'b0, 2'd0, 1'b0, 16'h0000, 4'b0000};
    tbl[7] = '{-1, 16'h0000, 1'b1, 2'd1, 1'b1, 16'h5500, 4'b0010};
    tbl[8] = '{-1, 16'h0000, 1'b0, 2'd0, 1'b0, 16'h0000, 4'b0000};

    ord[0] = 0; ord[1] = 1; ord[2] = 3;
    idata  = '0;
    iv     = '0;
    oready = 1'b1;
    lg_n   = 0;
    cyc_n  = 0;
    popf   = '0;

    // Reset values with every port requesting.
    rst = 1'b1;
    clear_q();
    for (int i = 0; i < P; i++) push(i, 16'h0001);
    refresh();
    #12;
    chk("rst busy", busy, 1'b0);
    chk("rst out_valid", ov, 1'b0);
    chk("rst in_ready", ir, 4'b0000);
    chk("rst grant", gnt, 2'd0);

    // Table-driven single-port packets.
    do_reset();
    for (int ri = 0; ri < 9; ri++) begin
      if (tbl[ri].ld_port >= 0) begin
        push(tbl[ri].ld_port, tbl[ri].ld_word);
        refresh();
      end
      #1;
      chk($sformatf("t[%0d] busy", ri), busy, tbl[ri].busy);
      chk($sformatf("t[%0d] out_valid", ri), ov, tbl[ri].ov);
      chk($sformatf("t[%0d] in_ready", ri), ir, tbl[ri].ir);
      if (tbl[ri].busy) chk($sformatf("t[%0d] grant", ri), gnt, tbl[ri].grant);
      if (tbl[ri].ov) chk($sformatf("t[%0d] out_data", ri), od, tbl[ri].od);
      cyc();
    end

    // Ports 0, 1, 3 each with two len=1 packets: round-robin order, one bubble each.
    do_reset();
    for (int kk = 0; kk < 2; kk++)
      for (int oi = 0; oi < 3; oi++) begin
        push(ord[oi], {4'(ord[oi]), 4'(kk), 8'h01});
        push(ord[oi], {4'(ord[oi]), 4'(kk), 8'hD0});
      end
    refresh();
    while (lg_n < 12 && cyc_n < 60) cyc();
    chk("rr xfer count", lg_n, 12);
    for (int j = 0; j < lg_n && j < 12; j++) begin
      pkt = j / 2;
      p   = ord[pkt % 3];
      k   = pkt / 3;
      w   = {4'(p), 4'(k), ((j % 2) == 0) ? 8'h01 : 8'hD0};
      chk($sformatf("rr[%0d] data", j), lg_data[j], w);
      chk($sformatf("rr[%0d] grant", j), lg_gnt[j], p);
      chk($sformatf("rr[%0d] cycle", j), lg_cyc[j], 3 * pkt + 1 + (j % 2));
    end

    // out_ready toggling during a port 0 len=4 packet while other ports wait.
    do_reset();
    push(0, 16'h0004);
    for (int i = 1; i <= 4; i++) push(0, 16'h00B0 + 16'(i));
    for (int i = 1; i < P; i++) push(i, 16'h0000);
    refresh();
    pat = 16'b1011_0110_0100_1011;
    while (lg_n < 5 && cyc_n < 40) begin
      oready = pat[cyc_n % 16];
      #1;
      if (cyc_n == 0) chk("tog idle in_ready", ir, 4'b0000);
      else chk($sformatf("tog c%0d in_ready", cyc_n), ir, {3'b000, oready});
      cyc();
    end
    oready = 1'b1;
    chk("tog xfer count", lg_n, 5);
    for (int j = 0; j < lg_n && j < 5; j++) begin
      chk($sformatf("tog[%0d] data", j), lg_data[j], (j == 0) ? 16'h0004 : 16'h00B0 + 16'(j));
      chk($sformatf("tog[%0d] grant", j), lg_gnt[j], 0);
    end

    // Maximum length: 256 transfers, no counter wrap.
    do_reset();
    push(2, 16'h00FF);
    for (int i = 1; i <= 255; i++) push(2, 16'h1000 + 16'(i));
    refresh();
    while (cyc_n < 400 && !(lg_n >= 256 && !busy)) cyc();
    chk("len255 xfer count", lg_n, 256);
    chk("len255 busy after", busy, 1'b0);
    chk("len255 end cycle", cyc_n, 257);
    bad = 0;
    for (int j = 0; j < lg_n && j < 256; j++)
      if (lg_data[j] !== ((j == 0) ? 16'h00FF : 16'h1000 + 16'(j)) || lg_gnt[j] != 2) bad++;
    chk("len255 data order", bad, 0);

    // Asynchronous reset mid-packet, then arbitration restarts from port 0.
    do_reset();
    push(0, 16'h0005);
    for (int i = 1; i <= 5; i++) push(0, 16'h00C0 + 16'(i));
    push(1, 16'h0000);
    refresh();
    repeat (4) cyc();
    chk("abort pre busy", busy, 1'b1);
    chk("abort pre data", od, 16'h00C3);
    #2 rst = 1'b1;
    #1;
    chk("abort out_valid", ov, 1'b0);
    chk("abort in_ready", ir, 4'b0000);
    chk("abort busy", busy, 1'b0);
    chk("abort grant", gnt, 2'd0);
    clear_q();
    push(0, 16'h0100);
    push(1, 16'h0000);
    refresh();
    @(negedge clk);
    rst   = 1'b0;
    cyc_n = 0;
    lg_n  = 0;
    repeat (5) cyc();
    chk("restart xfer count", lg_n, 2);
    chk("restart first grant", lg_gnt[0], 0);
    chk("restart first data", lg_data[0], 16'h0100);
    chk("restart first cycle", lg_cyc[0], 1);
    chk("restart second grant", lg_gnt[1], 1);
    chk("restart second cycle", lg_cyc[1], 3);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
